// File: rtl/uart_frame_decoder.sv
// Six-byte UART command-frame decoder: CMD, A_HI, A_LO, B_HI, B_LO, CHK.
// Presents a checked operand set to the FPU and reports header, checksum and timeout errors.
module uart_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        fpu_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [1:0]  opcode,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        overrun,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_AH, GET_AL, GET_BH, GET_BL, GET_CHK, ISSUE
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00, ERR_HDR = 2'b01, ERR_CHK = 2'b10, ERR_TMO = 2'b11
  } err_e;

  state_e           state_q,     state_d;
  logic [15:0]      op_a_q,      op_a_d;
  logic [15:0]      op_b_q,      op_b_d;
  logic [1:0]       opcode_q,    opcode_d;
  logic [7:0]       xor_q,       xor_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  err_e             err_code_q,  err_code_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q,   overrun_d;

  logic in_frame;
  logic hdr_ok;

  assign in_frame = (state_q == GET_AH) || (state_q == GET_AL) || (state_q == GET_BH)
                 || (state_q == GET_BL) || (state_q == GET_CHK);
  assign hdr_ok   = (rx_data[7:4] == 4'hA) && (rx_data[3:2] == 2'b00);

  // NOTE: every _d gets its hold value before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    xor_d       = xor_q;
    cnt_d       = '0;
    err_code_d  = err_code_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    // Inter-byte gap timer; a byte arriving on the terminal count takes priority.
    if (in_frame && !rx_valid) begin
      if (cnt_q == CNT_TERM) begin
        state_d     = IDLE;
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (hdr_ok) begin
            state_d  = GET_AH;
            opcode_d = rx_data[1:0];
            xor_d    = rx_data;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_HDR;
          end
        end
        GET_AH: begin
          op_a_d[15:8] = rx_data;
          xor_d        = xor_q ^ rx_data;
          state_d      = GET_AL;
        end
        GET_AL: begin
          op_a_d[7:0] = rx_data;
          xor_d       = xor_q ^ rx_data;
          state_d     = GET_BH;
        end
        GET_BH: begin
          op_b_d[15:8] = rx_data;
          xor_d        = xor_q ^ rx_data;
          state_d      = GET_BL;
        end
        GET_BL: begin
          op_b_d[7:0] = rx_data;
          xor_d       = xor_q ^ rx_data;
          state_d     = GET_CHK;
        end
        GET_CHK: begin
          if (rx_data == xor_q) begin
            state_d = ISSUE;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        ISSUE: overrun_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    if (state_q == ISSUE && fpu_ready) begin
      state_d = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      xor_q       <= '0;
      cnt_q       <= '0;
      err_code_q  <= ERR_NONE;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      xor_q       <= xor_d;
      cnt_q       <= cnt_d;
      err_code_q  <= err_code_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign opcode      = opcode_q;
  assign frame_valid = (state_q == ISSUE);
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, inter-byte timeout in clk cycles; legal range >= 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 rx_valid  input  1  one-cycle pulse: byte on rx_data is complete (UART receiver stop-state flag).
REQ-006 rx_data  input  8  received byte; sampled only when rx_valid=1.
REQ-007 fpu_ready  input  1  FPU accepts the operand set this cycle.
REQ-008 op_a  output  16  operand A, {A_HI, A_LO}.
REQ-009 op_b  output  16  operand B, {B_HI, B_LO}.
REQ-010 opcode  output  2  FPU operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-011 frame_valid  output  1  operand set valid; held until accepted.
REQ-012 frame_err  output  1  one-cycle error pulse.
REQ-013 err_code  output  2  cause of the last error: 01 bad header, 10 checksum, 11 timeout; 00 before the first error.
REQ-014 overrun  output  1  sticky: a byte arrived while the decoder held a frame.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Frame SHALL be 6 bytes: CMD, A_HI, A_LO, B_HI, B_LO, CHK.
REQ-017 CMD is valid iff CMD[7:4]=4'hA and CMD[3:2]=2'b00; opcode = CMD[1:0].
REQ-018 CHK is valid iff CHK = CMD ^ A_HI ^ A_LO ^ B_HI ^ B_LO (bitwise XOR, 8 bits).
REQ-019 FSM states SHALL be IDLE, GET_AH, GET_AL, GET_BH, GET_BL, GET_CHK, ISSUE.
REQ-020 IDLE: on rx_valid with a valid CMD -> GET_AH, latch opcode and start the running XOR; on an invalid CMD -> stay IDLE, set err_code=01.
REQ-021 GET_AH..GET_BL: each rx_valid latches the byte into the matching operand half and advances one state.
REQ-022 GET_CHK: on rx_valid with a matching CHK -> ISSUE; on a mismatch -> IDLE with err_code=10, and op_a/op_b are not presented.
REQ-023 ISSUE: frame_valid=1, with op_a, op_b and opcode stable; when fpu_ready=1 -> IDLE, and frame_valid=0 from the next cycle.
REQ-024 Latency: frame_valid SHALL rise in the cycle after the CHK byte's rx_valid cycle.
REQ-025 fpu_ready while not in ISSUE SHALL have no effect.
REQ-026 Timeout counter: cleared on every accepted byte; increments each cycle in GET_AH..GET_CHK when rx_valid=0; width = $clog2(TIMEOUT_CYCLES)+1.
REQ-027 When the counter = TIMEOUT_CYCLES-1 and rx_valid=0 -> IDLE with err_code=11; if rx_valid coincides with this terminal count, the byte SHALL win and the counter clears.
REQ-028 frame_err SHALL be a registered pulse, high exactly one cycle after the detecting cycle; err_code updates in the same cycle and holds until the next error.
REQ-029 After any error the FSM SHALL be in IDLE in the following cycle, so a byte arriving in the frame_err cycle is decoded as a CMD.
REQ-030 rx_valid in ISSUE: the byte SHALL be dropped, overrun set to 1, and op_a/op_b/opcode left unchanged.
REQ-031 Operand registers SHALL hold their last values outside ISSUE; their content is meaningful only while frame_valid=1.

Reset
REQ-032 On rst=1: state=IDLE, op_a=0, op_b=0, opcode=0, frame_valid=0, frame_err=0, err_code=00, overrun=0, busy=0, and the timeout counter and running XOR are cleared.
REQ-033 Reset mid-frame SHALL discard all partial bytes; after release, the next byte is treated as a CMD.
REQ-034 overrun SHALL be cleared only by rst.

Verification
REQ-035 Bytes A1,3C,00,40,00,DD with fpu_ready=1 -> one cycle after DD: frame_valid=1, op_a=3C00, op_b=4000, opcode=01; next cycle frame_valid=0, busy=0.
REQ-036 Header 51 -> frame_err pulses 1 cycle, err_code=01, busy stays 0; then the valid frame from REQ-035 is decoded correctly.
REQ-037 Bytes A1,3C,00,40,00,DC -> frame_err pulse with err_code=10, frame_valid never asserted, state IDLE.
REQ-038 TIMEOUT_CYCLES=16, bytes A2,12 only, with the last rx_valid at cycle t -> frame_err high at cycle t+17, err_code=11; a single rx_valid at the terminal count prevents the timeout.
REQ-039 Valid frame with fpu_ready=0 for 10 cycles and one extra byte 77 sent in ISSUE -> frame_valid held for 10 cycles, operands unchanged, overrun=1; the frame is accepted when fpu_ready=1.
REQ-040 rst pulse after A3,11,22 -> all outputs at reset values; a subsequent full valid frame decodes correctly.
